// File: rtl/hazard_controller.sv
// Pipeline hazard controller for a 5-stage MIPS: stalls, redirect flushes, EX forwarding selects.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_write_reg_i,
    input  logic       mem_reg_write_i,
    input  logic [4:0] mem_write_reg_i,
    input  logic       wb_reg_write_i,
    input  logic [4:0] wb_write_reg_i,
    input  logic       redirect_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       if_id_flush_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_flush_o,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

    if (STALL_CYCLES < 1 || STALL_CYCLES > 15 || CNT_W < 1) begin : g_param_err
        $error("hazard_controller: STALL_CYCLES must be 1..15 and CNT_W >= 1");
    end

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu;

    assign lu = ex_mem_read_i && ex_reg_write_i && (ex_write_reg_i != 5'd0) &&
                ((ex_write_reg_i == id_rs_i) || (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (redirect_i) begin
                    state_nxt = FLUSH;
                end else if (lu && STALL_CYCLES > 1) begin
                    state_nxt = STALL;
                    cnt_nxt   = STALL_INIT;
                end
            end
            STALL: begin
                if (redirect_i) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_reg_write_i && mem_write_reg_i != 5'd0 && mem_write_reg_i == src)
            return 2'b10;
        if (wb_reg_write_i && wb_write_reg_i != 5'd0 && wb_write_reg_i == src)
            return 2'b01;
        return 2'b00;
    endfunction

    // Reset forces the normal-flow pattern regardless of whatever the state register holds.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        fwd_a_sel_o    = 2'b00;
        fwd_b_sel_o    = 2'b00;
        state_o        = RUN;
        if (reset) begin
            state_o     = state;
            fwd_a_sel_o = fwd_sel(ex_rs_i);
            fwd_b_sel_o = fwd_sel(ex_rt_i);
            case (state)
                RUN, STALL: begin
                    if (redirect_i) begin
                        if_id_flush_o  = 1'b1;
                        id_ex_flush_o  = 1'b1;
                        ex_mem_flush_o = 1'b1;
                    end else if (state == STALL || lu) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic redirect_acc;
    assign redirect_acc = reset && redirect_i && (state != FLUSH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (redirect_acc && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`else
    // Counters excluded from this build.
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: three controllers (STALL_CYCLES 1/3/4) share stimulus; checks via immediate asserts.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
    logic       id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, redirect;

    logic       pcw1, ifw1, iff1, ief1, emf1;
    logic       pcw3, ifw3, iff3, ief3, emf3;
    logic       pcw4, ifw4, iff4, ief4, emf4;
    logic [1:0] fa1, fb1, st1, fa3, fb3, st3, fa4, fb4, st4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(.STALL_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
        .ex_write_reg_i(ex_wr), .mem_reg_write_i(mem_reg_write), .mem_write_reg_i(mem_wr),
        .wb_reg_write_i(wb_reg_write), .wb_write_reg_i(wb_wr), .redirect_i(redirect),
        .pc_write_o(pcw1), .if_id_write_o(ifw1), .if_id_flush_o(iff1), .id_ex_flush_o(ief1),
        .ex_mem_flush_o(emf1), .fwd_a_sel_o(fa1), .fwd_b_sel_o(fb1), .state_o(st1));

    hazard_controller #(.STALL_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
        .ex_write_reg_i(ex_wr), .mem_reg_write_i(mem_reg_write), .mem_write_reg_i(mem_wr),
        .wb_reg_write_i(wb_reg_write), .wb_write_reg_i(wb_wr), .redirect_i(redirect),
        .pc_write_o(pcw3), .if_id_write_o(ifw3), .if_id_flush_o(iff3), .id_ex_flush_o(ief3),
        .ex_mem_flush_o(emf3), .fwd_a_sel_o(fa3), .fwd_b_sel_o(fb3), .state_o(st3));

    hazard_controller #(.STALL_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
        .ex_write_reg_i(ex_wr), .mem_reg_write_i(mem_reg_write), .mem_write_reg_i(mem_wr),
        .wb_reg_write_i(wb_reg_write), .wb_write_reg_i(wb_wr), .redirect_i(redirect),
        .pc_write_o(pcw4), .if_id_write_o(ifw4), .if_id_flush_o(iff4), .id_ex_flush_o(ief4),
        .ex_mem_flush_o(emf4), .fwd_a_sel_o(fa4), .fwd_b_sel_o(fb4), .state_o(st4));

    // Control word: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, state[1:0]}
    localparam logic [6:0] C_NORM  = 7'b1100000;
    localparam logic [6:0] C_LU    = 7'b0001000;
    localparam logic [6:0] C_STALL = 7'b0001001;
    localparam logic [6:0] C_RDR   = 7'b1111100;
    localparam logic [6:0] C_RDRS  = 7'b1111101;
    localparam logic [6:0] C_FLUSH = 7'b1100010;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] e1, input logic [6:0] e3, input logic [6:0] e4);
        chk({tag, "/s1"}, {1'b0, pcw1, ifw1, iff1, ief1, emf1, st1}, {1'b0, e1});
        chk({tag, "/s3"}, {1'b0, pcw3, ifw3, iff3, ief3, emf3, st3}, {1'b0, e3});
        chk({tag, "/s4"}, {1'b0, pcw4, ifw4, iff4, ief4, emf4, st4}, {1'b0, e4});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        chk({tag, "/a"}, {6'd0, fa1}, {6'd0, ea});
        chk({tag, "/b"}, {6'd0, fb1}, {6'd0, eb});
        chk({tag, "/a4"}, {6'd0, fa4}, {6'd0, ea});
    endtask

    task automatic set_lu(input logic on);
        ex_mem_read  = on;
        ex_reg_write = on;
        ex_wr        = 5'd8;
        id_rs        = 5'd8;
    endtask

    initial begin
        reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_wr = 5'd0;
        mem_reg_write = 1'b0; mem_wr = 5'd0; wb_reg_write = 1'b0; wb_wr = 5'd0; redirect = 1'b0;

        // Reset held with redirect, load-use and forwarding conditions all active
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect = 1'b1; set_lu(1'b1);
            ex_rs = 5'd5; ex_rt = 5'd5; mem_reg_write = 1'b1; mem_wr = 5'd5;
            #1;
            chk_ctl("reset", C_NORM, C_NORM, C_NORM);
            chk_fwd("reset_fwd", 2'b00, 2'b00);
        end

        // Release with load-use present: first cycle reacts immediately
        @(negedge clk); reset = 1'b1; redirect = 1'b0; mem_reg_write = 1'b0; #1;
        chk_ctl("lu_c0", C_LU, C_LU, C_LU);
        @(negedge clk); set_lu(1'b0); #1;
        chk_ctl("lu_c1", C_NORM, C_STALL, C_STALL);
        @(negedge clk); #1;
        chk_ctl("lu_c2", C_NORM, C_STALL, C_STALL);
        @(negedge clk); #1;
        chk_ctl("lu_c3", C_NORM, C_NORM, C_STALL);
        @(negedge clk); #1;
        chk_ctl("lu_c4", C_NORM, C_NORM, C_NORM);

        // Redirect in RUN, then held during FLUSH (ignored along with load-use)
        @(negedge clk); redirect = 1'b1; #1;
        chk_ctl("rdr_run", C_RDR, C_RDR, C_RDR);
        @(negedge clk); set_lu(1'b1); #1;
        chk_ctl("rdr_flush", C_FLUSH, C_FLUSH, C_FLUSH);
        @(negedge clk); redirect = 1'b0; set_lu(1'b0); #1;
        chk_ctl("rdr_done", C_NORM, C_NORM, C_NORM);

        // Redirect on the 2nd stall cycle discards the remaining stall
        @(negedge clk); set_lu(1'b1); #1;
        chk_ctl("rs_c0", C_LU, C_LU, C_LU);
        @(negedge clk); set_lu(1'b0); redirect = 1'b1; #1;
        chk_ctl("rs_c1", C_RDR, C_RDRS, C_RDRS);
        @(negedge clk); redirect = 1'b0; #1;
        chk_ctl("rs_c2", C_FLUSH, C_FLUSH, C_FLUSH);
        @(negedge clk); #1;
        chk_ctl("rs_c3", C_NORM, C_NORM, C_NORM);

        // Forwarding: MEM beats WB, $0 never forwarded
        @(negedge clk);
        ex_rs = 5'd5; ex_rt = 5'd5; mem_reg_write = 1'b1; mem_wr = 5'd5; wb_reg_write = 1'b1; wb_wr = 5'd5;
        #1; chk_fwd("fwd_mem", 2'b10, 2'b10);
        @(negedge clk); mem_wr = 5'd0; #1;
        chk_fwd("fwd_wb", 2'b01, 2'b01);
        @(negedge clk); ex_rt = 5'd7; mem_wr = 5'd7; #1;
        chk_fwd("fwd_mix", 2'b01, 2'b10);
        @(negedge clk); mem_reg_write = 1'b0; wb_reg_write = 1'b0; #1;
        chk_fwd("fwd_none", 2'b00, 2'b00);
        @(negedge clk); ex_rs = 5'd0; ex_rt = 5'd0; mem_reg_write = 1'b1; mem_wr = 5'd0;
        wb_reg_write = 1'b1; wb_wr = 5'd0; #1;
        chk_fwd("fwd_r0", 2'b00, 2'b00);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // lw to $0 never stalls; rt match only counts when rt is a source
        @(negedge clk); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd0; id_rs = 5'd0; #1;
        chk_ctl("lu_r0", C_NORM, C_NORM, C_NORM);
        @(negedge clk); ex_wr = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0; #1;
        chk_ctl("lu_rt_unused", C_NORM, C_NORM, C_NORM);
        @(negedge clk); id_uses_rt = 1'b1; #1;
        chk_ctl("lu_rt_used", C_LU, C_LU, C_LU);
        @(negedge clk); ex_mem_read = 1'b0; ex_reg_write = 1'b0; #1;
        chk_ctl("lu_rt_next", C_NORM, C_STALL, C_STALL);

        // Reset mid-stall aborts back to RUN
        @(negedge clk); reset = 1'b0; #1;
        chk_ctl("rst_mid", C_NORM, C_NORM, C_NORM);
        @(negedge clk); reset = 1'b1; #1;
        chk_ctl("rst_after", C_NORM, C_NORM, C_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
